// File: rtl/dtg_sync_gen_if.sv
// Pixel-position and sync bus driven by the display timing generator.
// frameTick is present only when DTG_FRAME_TICK_EN is defined.
interface dtg_sync_gen_if;
    logic [9:0] pixCol;
    logic [9:0] pixRow;
    logic       hSync;
    logic       vSync;
    logic       videoOn;
`ifdef DTG_FRAME_TICK_EN
    logic       frameTick;

    modport master (output pixCol, pixRow, hSync, vSync, videoOn, frameTick);
    modport slave  (input  pixCol, pixRow, hSync, vSync, videoOn, frameTick);
`else
    modport master (output pixCol, pixRow, hSync, vSync, videoOn);
    modport slave  (input  pixCol, pixRow, hSync, vSync, videoOn);
`endif
endinterface

// File: rtl/dtg_sync_gen.sv
// VGA display timing generator: free-running pixel/line counters plus delayed sync/videoOn.
// Optional DTG_FRAME_TICK_EN adds a one-cycle frameTick at the start of vertical blank.
module dtg_sync_gen #(
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input logic            clk,
    input logic            reset,
    dtg_sync_gen_if.master vid
);

    localparam int unsigned H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = H_VIS + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = V_VIS + V_FP + V_SYNC;

    if (H_TOT > 1024 || V_TOT > 1024) begin : gBadTotals
        $error("dtg_sync_gen: H_TOT and V_TOT must fit 10-bit counters");
    end
    if (PIPE_DLY > 4) begin : gBadDelay
        $error("dtg_sync_gen: PIPE_DLY must be in 0..4");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);

    // Delay-line word layout: {hSync, vSync, videoOn}.
    localparam logic [2:0] IDLE_BITS = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [9:0] colQ;
    logic [9:0] rowQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            colQ <= '0;
            rowQ <= '0;
        end else if (colQ == H_LAST) begin
            colQ <= '0;
            rowQ <= (rowQ == V_LAST) ? '0 : rowQ + 10'd1;
        end else begin
            colQ <= colQ + 10'd1;
        end
    end

    logic       hSRaw;
    logic       vSRaw;
    logic       voRaw;
    logic [2:0] rawBits;
    logic [2:0] dlyOut;

    always_comb begin
        hSRaw = (32'(colQ) >= HS_START && 32'(colQ) < HS_END) ? SYNC_POL : ~SYNC_POL;
        vSRaw = (32'(rowQ) >= VS_START && 32'(rowQ) < VS_END) ? SYNC_POL : ~SYNC_POL;
        voRaw = (32'(colQ) < H_VIS) && (32'(rowQ) < V_VIS);
        rawBits = {hSRaw, vSRaw, voRaw};
    end

    if (PIPE_DLY == 0) begin : gNoDly
        // Counters sit at (0,0) in reset, which decodes as visible; force idle instead.
        assign dlyOut = reset ? rawBits : IDLE_BITS;
    end else begin : gDly
        logic [2:0] stageQ [PIPE_DLY];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int unsigned i = 0; i < PIPE_DLY; i++) begin
                    stageQ[i] <= IDLE_BITS;
                end
            end else begin
                stageQ[0] <= rawBits;
                for (int unsigned i = 1; i < PIPE_DLY; i++) begin
                    stageQ[i] <= stageQ[i-1];
                end
            end
        end

        assign dlyOut = stageQ[PIPE_DLY-1];
    end

    assign vid.pixCol  = colQ;
    assign vid.pixRow  = rowQ;
    assign vid.hSync   = dlyOut[2];
    assign vid.vSync   = dlyOut[1];
    assign vid.videoOn = dlyOut[0];

`ifdef DTG_FRAME_TICK_EN
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);

    assign vid.frameTick = (colQ == 10'd0) && (rowQ == V_VIS_L);
`endif

endmodule

// File: tb/tb_dtg_sync_gen.sv
// Scoreboard bench for dtg_sync_gen: three instances (default timing, and two scaled-down
// timings with PIPE_DLY 4 / 0) checked every cycle against an arithmetic timing model.
module tb_dtg_sync_gen;

    typedef struct {
        int hVis, hFp, hSync, hBp, vVis, vFp, vSync, vBp, dly;
        bit pol;
    } tim_t;

    typedef struct {
        int id;
        int n;
        int col, row;
        bit h, v, vo, ft;
    } obs_t;

    // Scaled timing: 32 x 19 = 608 cycles per frame.
    localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    dtg_sync_gen_if ifA ();
    dtg_sync_gen_if ifB ();
    dtg_sync_gen_if ifC ();

    dtg_sync_gen dutA (
        .clk   (clk),
        .reset (rstN),
        .vid   (ifA)
    );

    dtg_sync_gen #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b1), .PIPE_DLY(4)
    ) dutB (
        .clk   (clk),
        .reset (rstN),
        .vid   (ifB)
    );

    dtg_sync_gen #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b0), .PIPE_DLY(0)
    ) dutC (
        .clk   (clk),
        .reset (rstN),
        .vid   (ifC)
    );

    tim_t tims [3];
    obs_t expQ [$];
    event sampleEv;
    int   nTests = 0;
    int   nFail = 0;
    int   sinceRel = 0;
    bit   armed = 1'b0;
    int   aHsLow = 0, bVo = 0, bVs = 0, bHs = 0, cVo = 0, cVs = 0, bFt = 0, cFt = 0;

    // Expected outputs after n clock edges since reset release (n = 0 while in reset).
    function automatic obs_t model(tim_t t, int id, bit inRst, int n);
        obs_t e;
        int hTot, vTot, k, c, r;
        hTot = t.hVis + t.hFp + t.hSync + t.hBp;
        vTot = t.vVis + t.vFp + t.vSync + t.vBp;
        e.id = id;
        e.n = n;
        e.col = n % hTot;
        e.row = (n / hTot) % vTot;
`ifdef DTG_FRAME_TICK_EN
        e.ft = (e.col == 0) && (e.row == t.vVis);
`else
        e.ft = 1'b0;
`endif
        if (inRst || n < t.dly) begin
            e.h = ~t.pol;
            e.v = ~t.pol;
            e.vo = 1'b0;
        end else begin
            k = n - t.dly;
            c = k % hTot;
            r = (k / hTot) % vTot;
            e.h = (c >= t.hVis + t.hFp && c < t.hVis + t.hFp + t.hSync) ? t.pol : ~t.pol;
            e.v = (r >= t.vVis + t.vFp && r < t.vVis + t.vFp + t.vSync) ? t.pol : ~t.pol;
            e.vo = (c < t.hVis) && (r < t.vVis);
        end
        return e;
    endfunction

    function automatic obs_t grab(int id);
        obs_t a;
        a.id = id;
        a.n = 0;
        a.ft = 1'b0;
        case (id)
            0: begin
                a.col = int'(ifA.pixCol); a.row = int'(ifA.pixRow);
                a.h = ifA.hSync; a.v = ifA.vSync; a.vo = ifA.videoOn;
`ifdef DTG_FRAME_TICK_EN
                a.ft = ifA.frameTick;
`endif
            end
            1: begin
                a.col = int'(ifB.pixCol); a.row = int'(ifB.pixRow);
                a.h = ifB.hSync; a.v = ifB.vSync; a.vo = ifB.videoOn;
`ifdef DTG_FRAME_TICK_EN
                a.ft = ifB.frameTick;
`endif
            end
            default: begin
                a.col = int'(ifC.pixCol); a.row = int'(ifC.pixRow);
                a.h = ifC.hSync; a.v = ifC.vSync; a.vo = ifC.videoOn;
`ifdef DTG_FRAME_TICK_EN
                a.ft = ifC.frameTick;
`endif
            end
        endcase
        return a;
    endfunction

    // Monitor: pops every queued expectation when the DUT outputs are presented.
    always @(sampleEv) begin
        while (expQ.size() > 0) begin
            obs_t e;
            obs_t a;
            e = expQ.pop_front();
            a = grab(e.id);
            nTests++;
            if (a.col != e.col || a.row != e.row || a.h != e.h || a.v != e.v ||
                a.vo != e.vo || a.ft != e.ft) begin
                nFail++;
                $display("FAIL dut%0d n=%0d got col=%0d row=%0d h=%0b v=%0b vo=%0b ft=%0b want col=%0d row=%0d h=%0b v=%0b vo=%0b ft=%0b",
                         e.id, e.n, a.col, a.row, a.h, a.v, a.vo, a.ft,
                         e.col, e.row, e.h, e.v, e.vo, e.ft);
            end
        end
    end

    task automatic sample();
        int s;
        s = sinceRel;
        for (int i = 0; i < 3; i++) expQ.push_back(model(tims[i], i, !rstN, s));
        if (armed) begin
            if (s >= 3 && s <= 802 && ifA.hSync == 1'b0) aHsLow++;
            if (s >= 5 && s <= 612) begin
                if (ifB.videoOn) bVo++;
                if (ifB.vSync == 1'b1) bVs++;
                if (ifB.hSync == 1'b1) bHs++;
            end
            if (s >= 1 && s <= 608) begin
                if (ifC.videoOn) cVo++;
                if (ifC.vSync == 1'b0) cVs++;
            end
`ifdef DTG_FRAME_TICK_EN
            if (ifB.frameTick) bFt++;
            if (ifC.frameTick) cFt++;
`endif
        end
        ->sampleEv;
    endtask

    // Each step: edge, update model, then present expectations 2 time units later.
    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            if (rstN) sinceRel++;
            #2;
            sample();
        end
    endtask

    // Assert reset mid-cycle and check the asynchronous clear before the next edge.
    task automatic doReset(int hold);
        #1;
        rstN = 1'b0;
        sinceRel = 0;
        #1;
        sample();
        cycles(hold);
        #1;
        rstN = 1'b1;
    endtask

    task automatic chk(string name, int got, int want);
        nTests++;
        if (got != want) begin
            nFail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tims[0] = '{hVis: 640, hFp: 16, hSync: 96, hBp: 48,
                    vVis: 480, vFp: 10, vSync: 2, vBp: 33, dly: 2, pol: 1'b0};
        tims[1] = '{hVis: S_HV, hFp: S_HF, hSync: S_HS, hBp: S_HB,
                    vVis: S_VV, vFp: S_VF, vSync: S_VS, vBp: S_VB, dly: 4, pol: 1'b1};
        tims[2] = '{hVis: S_HV, hFp: S_HF, hSync: S_HS, hBp: S_HB,
                    vVis: S_VV, vFp: S_VF, vSync: S_VS, vBp: S_VB, dly: 0, pol: 1'b0};

        rstN = 1'b0;
        sinceRel = 0;
        cycles(10);
        #1;
        rstN = 1'b1;

        armed = 1'b1;
        cycles(2000);
        armed = 1'b0;

        // Land the default-timing instance on pixCol = 300, then reset mid-line.
        cycles((300 - sinceRel % 800 + 800) % 800);
        doReset(10);
        cycles(1500);

        for (int i = 0; i < 6; i++) begin
            cycles(int'($urandom_range(50, 1500)));
            doReset(int'($urandom_range(1, 5)));
        end
        cycles(700);

        #1;
        chk("queue drained", expQ.size(), 0);
        chk("dutA hSync low per line", aHsLow, 96);
        chk("dutB videoOn per frame", bVo, S_HV * S_VV);
        chk("dutB vSync asserted per frame", bVs, S_VS * 32);
        chk("dutB hSync asserted per frame", bHs, S_HS * 19);
        chk("dutC videoOn per frame", cVo, S_HV * S_VV);
        chk("dutC vSync asserted per frame", cVs, S_VS * 32);
`ifdef DTG_FRAME_TICK_EN
        chk("dutB frameTick pulses", bFt, 3);
        chk("dutC frameTick pulses", cFt, 3);
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
